// File: rtl/dec_strobe_seq.sv
// Registered active-low select generator with three operating modes:
// direct decode of addr_i, auto-scan with dwell/blanking for multiplexed
// displays and keypads, and a single timed strobe with a busy/done handshake.
// Every output is a flop, so board-level select lines never glitch.
module dec_strobe_seq #(
  parameter int ADDR_W  = 4,
  parameter int DWELL   = 4,
  parameter int BLANK   = 1,
  parameter int PULSE_W = 3,
  localparam int N_OUT  = 2 ** ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        en_n_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              req_i,
  output logic [N_OUT-1:0]  y_n_o,
  output logic [ADDR_W-1:0] sel_o,
  output logic              busy_o,
  output logic              done_o
);

  // One shared counter covers dwell, blanking and pulse width; it never has
  // to hold more than the largest of the three.
  localparam int CNT_MAX_A = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_MAX   = (CNT_MAX_A > PULSE_W) ? CNT_MAX_A : PULSE_W;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DWELL = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
  localparam logic [CNT_W-1:0] CNT_PULSE = CNT_W'(PULSE_W);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DIRECT     = 3'd1;
  localparam logic [2:0] SCAN_ON    = 3'd2;
  localparam logic [2:0] SCAN_BLANK = 3'd3;
  localparam logic [2:0] PULSE      = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx;   // current scan position

  // All ones except a single zero at position a, so at most one line is
  // ever low.
  function automatic logic [N_OUT-1:0] onehot_low(input logic [ADDR_W-1:0] a);
    logic [N_OUT-1:0] v;
    v    = '1;
    v[a] = 1'b0;
    return v;
  endfunction

  // Mode sequencer: the mode/enable inputs sampled at each edge choose the
  // next state and the registered outputs in one place, so an abort from
  // any state takes effect on the very next edge.
  // NOTE: every register here is assigned with <= so all flops update from
  // the same pre-edge values; a blocking = would let later lines see the
  // new value of state/cnt within the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      y_n_o  <= '1;
      sel_o  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (en_n_i != 2'b00 || mode_i == MODE_OFF) begin
        // Disabled or off: release every line, keep sel_o for software.
        state  <= IDLE;
        cnt    <= '0;
        y_n_o  <= '1;
        busy_o <= 1'b0;
      end else begin
        case (mode_i)
          MODE_DIRECT: begin
            state  <= DIRECT;
            cnt    <= '0;
            y_n_o  <= onehot_low(addr_i);
            sel_o  <= addr_i;
            busy_o <= 1'b0;
          end

          MODE_SCAN: begin
            busy_o <= 1'b0;
            if (state == SCAN_ON) begin
              if (cnt == CNT_DWELL) begin
                if (BLANK == 0) begin
                  // No blanking: step straight to the next line.
                  idx   <= idx + ADDR_W'(1);
                  sel_o <= idx + ADDR_W'(1);
                  y_n_o <= onehot_low(idx + ADDR_W'(1));
                  cnt   <= CNT_ONE;
                end else begin
                  state <= SCAN_BLANK;
                  y_n_o <= '1;
                  cnt   <= CNT_ONE;
                end
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else if (state == SCAN_BLANK) begin
              if (cnt == CNT_BLANK) begin
                state <= SCAN_ON;
                idx   <= idx + ADDR_W'(1);
                sel_o <= idx + ADDR_W'(1);
                y_n_o <= onehot_low(idx + ADDR_W'(1));
                cnt   <= CNT_ONE;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else begin
              // Entry into scan from any other state always restarts at 0.
              state <= SCAN_ON;
              idx   <= '0;
              sel_o <= '0;
              y_n_o <= onehot_low('0);
              cnt   <= CNT_ONE;
            end
          end

          default: begin  // pulse mode
            if (state == PULSE) begin
              // req_i and addr_i are deliberately ignored while busy.
              if (cnt == CNT_PULSE) begin
                state  <= IDLE;
                cnt    <= '0;
                y_n_o  <= '1;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else if (req_i) begin
              // Accepted from IDLE, including the done cycle, which gives
              // back-to-back strobes with a single high gap.
              state  <= PULSE;
              cnt    <= CNT_ONE;
              y_n_o  <= onehot_low(addr_i);
              sel_o  <= addr_i;
              busy_o <= 1'b1;
            end else begin
              state  <= IDLE;
              cnt    <= '0;
              y_n_o  <= '1;
              busy_o <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dec_strobe_seq.sv
// Directed testbench for dec_strobe_seq with default parameters
// (ADDR_W=4, DWELL=4, BLANK=1, PULSE_W=3). Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_dec_strobe_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  en_n_i;
  logic [1:0]  mode_i;
  logic [3:0]  addr_i;
  logic        req_i;
  logic [15:0] y_n_o;
  logic [3:0]  sel_o;
  logic        busy_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  dec_strobe_seq dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_n_i  (en_n_i),
    .mode_i  (mode_i),
    .addr_i  (addr_i),
    .req_i   (req_i),
    .y_n_o   (y_n_o),
    .sel_o   (sel_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle to the following falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic logic [15:0] low_at(input int a);
    logic [15:0] v;
    v    = 16'hFFFF;
    v[a] = 1'b0;
    return v;
  endfunction

  initial begin
    logic [15:0] ey;
    int          ph;
    int          sidx;

    rst_n_i = 1'b0;
    en_n_i  = 2'b00;
    mode_i  = 2'b00;
    addr_i  = 4'd5;
    req_i   = 1'b0;
    @(negedge clk_i);

    // Reset held for three edges.
    repeat (3) step();
    check("rst_y", 32'(y_n_o), 32'hFFFF);
    check("rst_sel", 32'(sel_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    rst_n_i = 1'b1;
    step();
    check("rel_y", 32'(y_n_o), 32'hFFDF);
    check("rel_sel", 32'(sel_o), 32'd5);

    // Direct decode against every enable combination.
    for (int e = 0; e < 4; e++) begin
      for (int a = 0; a < 16; a++) begin
        en_n_i = 2'(e);
        addr_i = 4'(a);
        step();
        ey = (e == 0) ? low_at(a) : 16'hFFFF;
        check($sformatf("dir_y_e%0d_a%0d", e, a), 32'(y_n_o), 32'(ey));
        // While disabled sel_o keeps the last enabled index (15).
        check($sformatf("dir_sel_e%0d_a%0d", e, a), 32'(sel_o), (e == 0) ? 32'(a) : 32'd15);
      end
    end

    // Scan: period 5 (4 low, 1 blank), wraps after index 15.
    en_n_i = 2'b00;
    mode_i = 2'b01;
    for (int c = 1; c <= 85; c++) begin
      step();
      ph   = (c - 1) % 5;
      sidx = ((c - 1) / 5) % 16;
      ey   = (ph < 4) ? low_at(sidx) : 16'hFFFF;
      check($sformatf("scan_y_c%0d", c), 32'(y_n_o), 32'(ey));
      check($sformatf("scan_sel_c%0d", c), 32'(sel_o), 32'(sidx));
      check($sformatf("scan_1hot_c%0d", c), 32'($countones(~y_n_o) <= 1), 32'd1);
    end

    // Reset mid-scan returns everything to reset values on the next edge.
    rst_n_i = 1'b0;
    step();
    check("rst_scan_y", 32'(y_n_o), 32'hFFFF);
    check("rst_scan_sel", 32'(sel_o), 32'd0);
    check("rst_scan_busy", 32'(busy_o), 32'd0);
    rst_n_i = 1'b1;

    // Single pulse on index 9; a request for index 2 mid-pulse is ignored.
    mode_i = 2'b10;
    addr_i = 4'd9;
    step();
    check("pidle_y", 32'(y_n_o), 32'hFFFF);
    check("pidle_busy", 32'(busy_o), 32'd0);
    req_i = 1'b1;
    step();
    req_i = 1'b0;
    check("p1_y", 32'(y_n_o), 32'hFDFF);
    check("p1_busy", 32'(busy_o), 32'd1);
    check("p1_sel", 32'(sel_o), 32'd9);
    check("p1_done", 32'(done_o), 32'd0);
    req_i  = 1'b1;
    addr_i = 4'd2;
    step();
    req_i = 1'b0;
    check("p2_y", 32'(y_n_o), 32'hFDFF);
    check("p2_busy", 32'(busy_o), 32'd1);
    step();
    check("p3_y", 32'(y_n_o), 32'hFDFF);
    check("p3_sel", 32'(sel_o), 32'd9);
    step();
    check("pdone_y", 32'(y_n_o), 32'hFFFF);
    check("pdone_busy", 32'(busy_o), 32'd0);
    check("pdone_done", 32'(done_o), 32'd1);
    check("pdone_sel", 32'(sel_o), 32'd9);
    step();
    check("pafter_done", 32'(done_o), 32'd0);
    check("pafter_y", 32'(y_n_o), 32'hFFFF);

    // Back-to-back: req held high gives 3 low, 1 high (done) repeating.
    addr_i = 4'd4;
    req_i  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      ph = (c - 1) % 4;
      check($sformatf("b2b_y_c%0d", c), 32'(y_n_o), (ph < 3) ? 32'hFFEF : 32'hFFFF);
      check($sformatf("b2b_busy_c%0d", c), 32'(busy_o), (ph < 3) ? 32'd1 : 32'd0);
      check($sformatf("b2b_done_c%0d", c), 32'(done_o), (ph == 3) ? 32'd1 : 32'd0);
    end
    req_i = 1'b0;
    step();
    check("b2b_end_y", 32'(y_n_o), 32'hFFFF);
    check("b2b_end_done", 32'(done_o), 32'd0);

    // Abort a pulse by switching to scan: no done, scan restarts at 0.
    addr_i = 4'd9;
    req_i  = 1'b1;
    step();
    req_i = 1'b0;
    step();
    check("ab_pre_y", 32'(y_n_o), 32'hFDFF);
    mode_i = 2'b01;
    step();
    check("ab_y", 32'(y_n_o), 32'hFFFE);
    check("ab_sel", 32'(sel_o), 32'd0);
    check("ab_busy", 32'(busy_o), 32'd0);
    check("ab_done", 32'(done_o), 32'd0);
    step();
    check("ab2_y", 32'(y_n_o), 32'hFFFE);
    check("ab2_done", 32'(done_o), 32'd0);

    // Mode 11 releases the lines and keeps sel_o.
    mode_i = 2'b11;
    step();
    check("off_y", 32'(y_n_o), 32'hFFFF);
    check("off_sel", 32'(sel_o), 32'd0);
    check("off_done", 32'(done_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_strobe_seq.md
Name: dec_strobe_seq

Overview:
Parametrised, registered successor of the team's 4-to-16 active-low decoder. It adds clocked operation with three modes. Direct decode, auto-scan with dwell and blanking for multiplexed displays and keypads, and a single timed strobe with a busy/done handshake. It sits between the SoC GPIO/peripheral bus and board-level select lines (chip selects, digit drivers).

Parameters:
ADDR_W, 4, select index width; N_OUT = 2**ADDR_W outputs
DWELL, 4, cycles each output is held low in scan mode (>=1)
BLANK, 1, all-high cycles inserted between scan steps (>=0)
PULSE_W, 3, low cycles of a pulse-mode strobe (>=1)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  synchronous reset, active low
en_n_i  input  2  enables, active low; block enabled only when both bits are 0
mode_i  input  2  00 direct, 01 scan, 10 pulse, 11 off
addr_i  input  ADDR_W  select index (direct decode; captured on pulse req)
req_i  input  1  pulse request, sampled in pulse mode only
y_n_o  output  N_OUT  active-low one-hot select outputs, registered
sel_o  output  ADDR_W  index of the currently or last asserted output
busy_o  output  1  pulse in progress
done_o  output  1  one-cycle pulse-complete strobe

Behaviour:
- Reset (rst_n_i=0 at an edge): y_n_o all ones, sel_o=0, busy_o=0, done_o=0, counters=0, state IDLE. Reset mid-operation aborts immediately, with no done_o.
- All outputs are registered. Decisions use inputs sampled at edge k and appear after edge k.
- At most one bit of y_n_o is 0 at any time. Unused outputs are always 1.
- States: IDLE, DIRECT, SCAN_ON, SCAN_BLANK, PULSE.
- Disabled (en_n_i!=00) or mode_i=11: next state IDLE, y_n_o all ones, busy_o=0, no done_o. sel_o holds.
- DIRECT: y_n_o[addr_i]=0 one cycle after sampling, sel_o=addr_i. It tracks addr_i every cycle.
- SCAN entry (mode changes to 01, or re-enable in 01):
  - Start at index 0. y_n_o[0]=0 for DWELL cycles.
  - Then BLANK cycles with all ones. sel_o holds during blank.
  - Then index+1. sel_o updates with the new strobe.
  - Index wraps from N_OUT-1 to 0.
  - Step period is DWELL+BLANK. BLANK=0 goes directly ON to ON.
- PULSE (mode 10):
  - In IDLE with req_i=1 at edge k: capture addr_i.
  - Edges k+1 .. k+PULSE_W: y_n_o[addr]=0, busy_o=1, sel_o=addr.
  - Edge k+PULSE_W+1: y_n_o all ones, busy_o=0, done_o=1 for exactly one cycle. State returns to IDLE.
  - req_i while busy_o=1 is ignored. addr_i changes during a pulse are ignored.
  - req_i sampled in the done cycle is accepted, giving back-to-back strobes with exactly one all-high gap cycle.
- Mode change mid-operation: current activity is aborted with no done_o. The new mode starts from its entry condition on the next edge (scan restarts at index 0).
- Counters sized $clog2(max(DWELL,BLANK,PULSE_W)+1). No overflow is possible.

Test Plan:
- Reset: hold rst_n_i=0 for 3 cycles with mode 00, addr 5, en 00 -> y_n_o=16'hFFFF, sel_o=0, busy_o=0, done_o=0. After release, next cycle y_n_o=16'hFFDF.
- Direct/enable sweep: addr 0..15 with en_n_i in {00,01,10,11} -> for en 00, one cycle later y_n_o=~(1<<addr); otherwise y_n_o=16'hFFFF. This matches the 74HC154 truth table with one-cycle latency.
- Scan, DWELL=4, BLANK=1: enter mode 01 and run 85 cycles -> y_n_o[0] low for cycles 1-4, all high at cycle 5, y_n_o[1] low for cycles 6-9. Wrap is seen: y_n_o[15] low for cycles 76-79, all high at 80, y_n_o[0] low at 81. One-hot holds every cycle.
- Pulse, PULSE_W=3: mode 10, addr 9, req at edge 10 -> y_n_o=16'hFDFF and busy_o=1 for edges 11-13; edge 14 all ones, done_o=1 for one cycle. A req with addr 2 at edge 12 is ignored.
- Back-to-back pulses: req held high continuously -> pattern of 3 low cycles, 1 high cycle (done_o=1), repeating.
- Aborts: during a pulse, switch to mode 01 at edge 12 -> no done_o, scan starts at index 0. Assert rst_n_i=0 mid-scan -> all outputs return to reset values on the next edge.
